// File: rtl/sram_ctrl.sv
// Async SRAM controller, one request in flight; write 1 cycle, read 2+RD_WAIT cycles to rsp_valid.
// Backpressure: req_ready only in IDLE, and a new request may be taken in the same cycle as rsp_valid.
module sram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14,
    parameter int RD_WAIT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  sram_csb,
    output logic                  sram_web,
    output logic                  sram_oeb,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_ADDR = 2'd2,
        RD_DATA = 2'd3
    } state_t;

    localparam logic [2:0] WAIT_LAST = 3'(RD_WAIT);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [2:0]            cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic                  oeb_q, oeb_d;
    logic                  drv_q, drv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            drv_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            drv_q       <= drv_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        cnt_d       = cnt_q + 3'd1;
        rsp_valid_d = 1'b0;
        req_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                cnt_d     = cnt_q;
                if (req_valid) begin
                    addr_d = req_addr;
                    if (req_we) begin
                        wdata_d = req_wdata;
                        state_d = WR;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            WR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
            end
            RD_ADDR: begin
                cnt_d   = '0;
                state_d = RD_DATA;
            end
            RD_DATA: begin
                if (cnt_q == WAIT_LAST) begin
                    rdata_d     = sram_data;
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pins are registered from the next state so strobes come straight off flops.
        csb_d = (state_d == IDLE);
        web_d = (state_d != WR);
        oeb_d = (state_d != RD_DATA);
        drv_d = (state_d == WR);
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_addr = addr_q;
    assign sram_csb  = csb_q;
    assign sram_web  = web_q;
    assign sram_oeb  = oeb_q;
    assign sram_data = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three builds (RD_WAIT 1, 0, 7) share stimulus, each with its own SRAM model and scoreboard.
`timescale 1ns/1ps
module tb_sram_ctrl;

    localparam int DW = 32;
    localparam int AW = 14;
    localparam int NI = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [NI-1:0] mask = '1;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    logic [NI-1:0] rdy_all, rv_all, csb_all, web_all, oeb_all;
    logic [DW-1:0] rd_all [NI];
    logic [AW-1:0] sa_all [NI];

    typedef struct {
        int            acc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } sb_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 0 : 7;
        logic          rdy, rv, csb, web, oeb;
        logic [AW-1:0] sa;
        logic [DW-1:0] rdata;
        wire  [DW-1:0] sd;
        logic          mdl_oe = 1'b0;
        logic [DW-1:0] mdl_dat = '0;
        logic [DW-1:0] mem    [0:(1<<AW)-1];
        logic [DW-1:0] shadow [0:(1<<AW)-1];
        sb_t           sb [$];

        sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_WAIT(W)) u_dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid & mask[g]), .req_ready(rdy),
            .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rv), .rsp_rdata(rdata),
            .sram_addr(sa), .sram_csb(csb), .sram_web(web), .sram_oeb(oeb),
            .sram_data(sd)
        );

        assign sd = mdl_oe ? mdl_dat : {DW{1'bz}};
        assign rdy_all[g] = rdy;
        assign rv_all[g]  = rv;
        assign csb_all[g] = csb;
        assign web_all[g] = web;
        assign oeb_all[g] = oeb;
        assign rd_all[g]  = rdata;
        assign sa_all[g]  = sa;

        initial begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i]    = '0;
                shadow[i] = '0;
            end
        end

        // SRAM model: output appears 3 ns after the controls settle.
        always begin
            @(csb or oeb or web or sa);
            #3;
            mdl_oe  = !csb && !oeb && web;
            mdl_dat = mem[sa];
        end

        always @(posedge clk) begin
            if (!csb && !web) mem[sa] = sd;
        end

        always @(negedge clk) begin
            sb_t e;
            if (rst) begin
                sb.delete();
            end else begin
                if (!csb) check($sformatf("bus_conflict%0d", g), 64'(!web && !oeb), 64'(0));
                if (rv) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL spurious_rsp%0d: rsp_valid=1 expected 0 at cycle %0d", g, cyc);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("latency%0d", g), 64'(cyc - e.acc), 64'(e.we ? 1 : 2 + W));
                        if (e.we) shadow[e.addr] = e.wdata;
                        else check($sformatf("rdata%0d@%0h", g, e.addr), 64'(rdata), 64'(shadow[e.addr]));
                    end
                end
                if (req_valid && mask[g] && rdy) sb.push_back('{cyc + 1, req_we, req_addr, req_wdata});
            end
        end
    end

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((g_dut[0].sb.size() + g_dut[1].sb.size() + g_dut[2].sb.size()) != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("wait_idle_timeout", 64'(n >= 40), 64'(0));
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, "_csb"}, 64'(csb_all[0]), 64'(1));
        check({tag, "_web"}, 64'(web_all[0]), 64'(1));
        check({tag, "_oeb"}, 64'(oeb_all[0]), 64'(1));
        check({tag, "_addr"}, 64'(sa_all[0]), 64'(0));
        check({tag, "_rsp_valid"}, 64'(rv_all[0]), 64'(0));
        check({tag, "_rdata"}, 64'(rd_all[0]), 64'(0));
    endtask

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 14'h0005, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b1, 14'h0000, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 14'h3FFF, 32'h0F0F0F0F, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 14'h0000, 32'h0,        32'hA5A5A5A5};
        vecs[4] = '{1'b0, 14'h3FFF, 32'h0,        32'h0F0F0F0F};
        vecs[5] = '{1'b1, 14'h0005, 32'h11111111, 32'h0F0F0F0F};
        vecs[6] = '{1'b0, 14'h0005, 32'h0,        32'h11111111};
        vecs[7] = '{1'b0, 14'h0000, 32'h0,        32'hA5A5A5A5};

        repeat (2) @(posedge clk);
        #1;
        check_reset_pins("reset");
        rst = 1'b0;
        #1;
        for (int g = 0; g < NI; g++) check($sformatf("ready_after_reset%0d", g), 64'(rdy_all[g]), 64'(1));

        // Single write, pins checked during the WR cycle.
        issue(1'b1, 14'h0005, 32'hDEADBEEF);
        #2;
        check("wr_csb", 64'(csb_all[0]), 64'(0));
        check("wr_web", 64'(web_all[0]), 64'(0));
        check("wr_oeb", 64'(oeb_all[0]), 64'(1));
        check("wr_addr", 64'(sa_all[0]), 64'(14'h0005));
        check("wr_bus", 64'(g_dut[0].sd), 64'(32'hDEADBEEF));
        check("wr_ready", 64'(rdy_all[0]), 64'(0));
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            wait_idle();
            for (int g = 0; g < NI; g++)
                check($sformatf("vec%0d_rdata%0d", i, g), 64'(rd_all[g]), 64'(vecs[i].exp_rdata));
        end

        // Back-to-back write then read with req_valid held high.
        mask = 3'b001;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 14'h3FFF;
        req_wdata = 32'h12345678;
        @(posedge clk);
        #1;
        req_we = 1'b0;
        check("b2b_ready_in_wr", 64'(rdy_all[0]), 64'(0));
        @(posedge clk);
        #1;
        check("b2b_rsp_valid", 64'(rv_all[0]), 64'(1));
        check("b2b_ready_with_rsp", 64'(rdy_all[0]), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("b2b_read_taken", 64'(rdy_all[0]), 64'(0));
        wait_idle();
        check("b2b_rdata", 64'(rd_all[0]), 64'(32'h12345678));

        mask = '1;
        for (int i = 0; i < 40; i++) begin
            issue(1'($urandom_range(0, 1)), 14'h0040 + 14'($urandom_range(0, 15)), $urandom);
            wait_idle();
        end

        // Reset during RD_DATA.
        mask = 3'b001;
        issue(1'b0, 14'h0005, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_pins("rst_rd");
        check("rst_rd_ready", 64'(rdy_all[0]), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_rd_ready_after", 64'(rdy_all[0]), 64'(1));
        repeat (12) @(negedge clk);

        // Reset during WR must leave the target word untouched.
        mask = '1;
        issue(1'b1, 14'h0100, 32'hCAFEF00D);
        wait_idle();
        mask = 3'b001;
        issue(1'b1, 14'h0100, 32'hBADBAD00);
        #1;
        rst = 1'b1;
        #1;
        check_reset_pins("rst_wr");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_wr_mem", 64'(g_dut[0].mem[14'h0100]), 64'(32'hCAFEF00D));
        mask = '1;
        issue(1'b0, 14'h0100, 32'h0);
        wait_idle();
        for (int g = 0; g < NI; g++) check($sformatf("rst_wr_readback%0d", g), 64'(rd_all[g]), 64'(32'hCAFEF00D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the word width of the data bus and request/response data.
REQ-002 Parameter ADDR_WIDTH, default 14, SHALL set the word-address width (16384 words).
REQ-003 Parameter RD_WAIT, default 1, range 0..7, SHALL set extra output-enabled cycles before read data capture.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 req_valid  input  1  SHALL indicate a pending core request.
REQ-007 req_ready  output  1  SHALL indicate the block accepts a request this cycle.
REQ-008 req_we  input  1  SHALL select write (1) or read (0).
REQ-009 req_addr  input  ADDR_WIDTH  SHALL be the word address.
REQ-010 req_wdata  input  DATA_WIDTH  SHALL be the write data.
REQ-011 rsp_valid  output  1  SHALL pulse one cycle per completed request (read or write).
REQ-012 rsp_rdata  output  DATA_WIDTH  SHALL hold the most recently captured read data.
REQ-013 sram_addr  output  ADDR_WIDTH  SHALL drive the SRAM address pins.
REQ-014 sram_csb / sram_web / sram_oeb  output  1 each  SHALL drive active-low chip select, write enable, output enable.
REQ-015 sram_data  inout  DATA_WIDTH  SHALL be the bidirectional SRAM data bus.

Function
REQ-016 States SHALL be IDLE, WR, RD_ADDR, RD_DATA; req_ready SHALL equal (state==IDLE).
REQ-017 Handshake: request accepted at a rising edge where req_valid && req_ready; addr, we, wdata registered at that edge and held stable until return to IDLE.
REQ-018 IDLE: csb=1, web=1, oeb=1, sram_data released (Z); accepted write -> WR, accepted read -> RD_ADDR.
REQ-019 WR (exactly 1 cycle): csb=0, web=0, oeb=1, sram_data driven with registered wdata; next state IDLE with rsp_valid=1.
REQ-020 RD_ADDR (exactly 1 cycle): csb=0, web=1, oeb=1, sram_data released; next state RD_DATA, wait counter cleared.
REQ-021 RD_DATA (RD_WAIT+1 cycles): csb=0, web=1, oeb=0, sram_data released; counter increments each edge; at the edge where counter==RD_WAIT, sram_data SHALL be captured into rsp_rdata, state -> IDLE, rsp_valid=1.
REQ-022 Latency from acceptance edge N: write rsp_valid high in cycle following edge N+1; read rsp_valid high in cycle following edge N+2+RD_WAIT.
REQ-023 rsp_valid SHALL be high exactly one cycle per request, never for a request not accepted.
REQ-024 Back-to-back: a new request SHALL be acceptable in the same cycle rsp_valid is high (IDLE), with no dead cycle.
REQ-025 Block SHALL drive sram_data only in WR; web=0 whenever driven, so no bus contention with SRAM (SRAM drives only when csb=0, oeb=0, web=1).
REQ-026 rsp_rdata SHALL be unchanged by write requests and between reads.
REQ-027 sram_addr SHALL equal the registered request address in all non-IDLE states; in IDLE it holds its last value.

Reset
REQ-028 On rst assertion, asynchronously: state=IDLE, csb=1, web=1, oeb=1, sram_addr=0, rsp_valid=0, rsp_rdata=0, counter=0, sram_data released.
REQ-029 Reset mid-request SHALL abort it: no SRAM write completes after reset, no rsp_valid is issued for it.
REQ-030 After rst deassertion, req_ready SHALL be 1 in the first cycle.

Verification
REQ-031 Write 0xDEADBEEF to addr 0x0005 -> one WR cycle with csb=0, web=0, sram_data=0xDEADBEEF, sram_addr=0x0005; rsp_valid one cycle after.
REQ-032 Read addr 0x0005 after REQ-031, RD_WAIT=1, SRAM model 3-time-unit output delay -> rsp_rdata=0xDEADBEEF, rsp_valid 3 edges after acceptance.
REQ-033 Back-to-back write 0x3FFF=0x12345678 then read 0x3FFF, req_valid held high -> second request accepted in rsp_valid cycle; read returns 0x12345678.
REQ-034 Bus check over random read/write mix -> sram_data never driven by block while oeb=0; X never captured.
REQ-035 Assert rst during RD_DATA and during WR -> outputs at reset values immediately, no rsp_valid, target word unchanged on aborted write.
REQ-036 RD_WAIT=0 and RD_WAIT=7 builds -> read latency 2 and 9 edges respectively, data correct.
